// File: rtl/mem_port_arbiter.sv
// Two-requester memory port: fetch and data share one registered memory interface.
// One access in flight at a time (IDLE -> ISSUE -> RESP); data has priority with starvation relief for fetch.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_funct3,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [15:0]       stall_q, stall_d;
  logic              own_fetch_q, own_store_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_read_q, mem_write_q;
  logic [2:0]        mem_funct3_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_valid_q, d_valid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic idle, d_req, fetch_win, mem_go;

  // funct3[1:0]: 00 byte, 01 half, 10 word, 11 treated as byte-aligned
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    misaligned = ((f3[1:0] == 2'b10) && (a != 2'b00)) ||
                 ((f3[1:0] == 2'b01) && a[0]);
  endfunction

  always_comb begin
    d_req      = d_read | d_write;
    idle       = (state_q == S_IDLE) && !rst;
    fetch_win  = if_req && (!d_req || (starve_q == STARVE_LIM));
    if_ready   = idle && fetch_win;
    d_ready    = idle && d_req && !fetch_win;
    d_misalign = d_ready && misaligned(d_funct3, d_addr[1:0]);
    mem_go     = if_ready || (d_ready && !d_misalign);

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mem_go) state_d = S_ISSUE;
      S_ISSUE: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase

    starve_d = starve_q;
    if (if_ready)
      starve_d = '0;
    else if (idle && if_req && (starve_q != STARVE_LIM))
      starve_d = starve_q + SW'(1);

    stall_d = stall_q;
    if (if_req && !if_ready && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      starve_q     <= '0;
      stall_q      <= '0;
      own_fetch_q  <= 1'b0;
      own_store_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_funct3_q <= '0;
      mem_wdata_q  <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;

      // grant edge: latch the winner onto the memory port
      if (mem_go) begin
        mem_addr_q   <= if_ready ? if_addr : d_addr;
        mem_read_q   <= if_ready || !d_write;
        mem_write_q  <= !if_ready && d_write;
        mem_funct3_q <= if_ready ? 3'b010 : d_funct3;
        if (!if_ready)
          mem_wdata_q <= d_wdata;
        own_fetch_q  <= if_ready;
        own_store_q  <= !if_ready && d_write;
      end else if (state_q == S_ISSUE) begin
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
      end

      // response edge: memory data is valid now
      if (state_q == S_RESP) begin
        if (own_fetch_q) begin
          if_rdata_q <= mem_rdata;
          if_valid_q <= 1'b1;
        end else begin
          d_valid_q <= 1'b1;
          if (!own_store_q)
            d_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_funct3 = mem_funct3_q;
  assign mem_wdata  = mem_wdata_q;
  assign if_valid   = if_valid_q;
  assign if_rdata   = if_rdata_q;
  assign d_valid    = d_valid_q;
  assign d_rdata    = d_rdata_q;
  assign stall_cnt  = stall_q;

endmodule
